// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and defaults for the memory port arbiter:
//               FSM state encoding, requester owner encoding, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  // Default geometry of the shared data memory port
  localparam int unsigned C_ADR_W   = 13;
  localparam int unsigned C_DATA_W  = 16;
  localparam int unsigned C_MEM_LAT = 2;

  // Latency counter wide enough for MEM_LAT-1 with MEM_LAT up to 7
  localparam int unsigned C_CNT_W   = 3;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  // Owner of the current access
  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational winner selection between the fetch (F) and
//               load/store (D) requesters. A lone request always wins; on a
//               tie the pointer input decides (OWN_F -> F, otherwise D).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic f_req,
  input  logic d_req,
  input  logic ptr,
  output logic grant,
  output logic owner
);

  // Pick the winning requester for this cycle
  always_comb begin
    grant = f_req | d_req;
    owner = OWN_D;
    if (f_req && d_req) begin
      owner = (ptr == OWN_F) ? OWN_F : OWN_D;
    end else if (f_req) begin
      owner = OWN_F;
    end
  end

endmodule : mem_arb_pick

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares the single-port data memory between instruction fetch
//               (read-only) and the load/store unit (read/write). Each access
//               runs IDLE -> ACCESS -> RESP; reads hold mem_re for MEM_LAT
//               cycles before capturing mem_rdata, writes pulse mem_we once.
//               The owner's ack pulses for one cycle in RESP.
// Config      : MEM_ARB_ROUND_ROBIN_EN - when defined, ties are resolved by a
//               1-bit round-robin pointer (resets to F, flips on every RESP);
//               when undefined, D always wins a tie.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = C_MEM_LAT,  // legal range 1..7
  parameter int unsigned ADR_W   = C_ADR_W,
  parameter int unsigned DATA_W  = C_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  // fetch requester
  input  logic              f_req,
  input  logic [ADR_W-1:0]  f_adr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  // load/store requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADR_W-1:0]  d_adr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  // memory side
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADR_W-1:0]  mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(MEM_LAT - 1);

  arb_state_e          state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADR_W-1:0]    adr_q, adr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [C_CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic                tie_ptr;
  logic                pick_grant;
  logic                pick_owner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  // Round-robin pointer hands the next tie to the other requester after each RESP
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == RESP) begin
      ptr_d = ~ptr_q;
    end
  end

  // Pointer register, starts favouring fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= OWN_F;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign tie_ptr = ptr_q;
`else
  // Fixed priority: load/store wins every tie
  assign tie_ptr = OWN_D;
`endif

  mem_arb_pick u_pick (
    .f_req (f_req),
    .d_req (d_req),
    .ptr   (tie_ptr),
    .grant (pick_grant),
    .owner (pick_owner)
  );

  // Next-state, latency counter and datapath register updates
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    adr_d     = adr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (pick_grant) begin
          owner_d = pick_owner;
          cnt_d   = C_CNT_LOAD;
          state_d = ACCESS;
          if (pick_owner == OWN_D) begin
            we_d    = d_we;
            adr_d   = d_adr;
            wdata_d = d_wdata;
          end else begin
            // fetch is read-only; no write data to carry
            we_d    = 1'b0;
            adr_d   = f_adr;
            wdata_d = '0;
          end
        end
      end

      ACCESS: begin
        if (we_q) begin
          // the write is committed on the single mem_we cycle
          state_d = RESP;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (owner_q == OWN_F) begin
            f_rdata_d = mem_rdata;
          end else begin
            d_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and datapath registers; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_F;
      we_q      <= 1'b0;
      adr_q     <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Memory strobes and acks decode straight from the registered state
  always_comb begin
    mem_re = (state_q == ACCESS) && !we_q;
    mem_we = (state_q == ACCESS) &&  we_q;
    f_ack  = (state_q == RESP) && (owner_q == OWN_F);
    d_ack  = (state_q == RESP) && (owner_q == OWN_D);
    busy   = (state_q != IDLE);
  end

  assign mem_adr   = adr_q;
  assign mem_wdata = wdata_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule : mem_port_arbiter

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. Drives directed and
//               random F/D requests against a simple memory and a
//               transaction-level reference (shadow memory, expected ack
//               cycle, expected service order).
// Config      : MEM_ARB_ROUND_ROBIN_EN selects the round-robin tie model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned ADR_W   = 13;
  localparam int unsigned DATA_W  = 16;

  logic              clk;
  logic              rst;
  logic              f_req;
  logic [ADR_W-1:0]  f_adr;
  logic              f_ack;
  logic [DATA_W-1:0] f_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADR_W-1:0]  d_adr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_re;
  logic              mem_we;
  logic [ADR_W-1:0]  mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  int n_checks;
  int n_errors;

  // memory behind the arbiter and the bench's own view of its contents
  logic [DATA_W-1:0] mem_arr [0:1023];
  logic [DATA_W-1:0] ref_mem [0:1023];
  logic [DATA_W-1:0] hold_f_rdata;
  logic [DATA_W-1:0] hold_d_rdata;
  bit                f_turn;  // round-robin model: 1 = F wins next tie

  mem_port_arbiter #(
    .MEM_LAT (MEM_LAT),
    .ADR_W   (ADR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .f_req     (f_req),
    .f_adr     (f_adr),
    .f_ack     (f_ack),
    .f_rdata   (f_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_adr     (d_adr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single-port memory: synchronous write, combinational read
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_adr[9:0]] <= mem_wdata;
  end
  assign mem_rdata = mem_arr[mem_adr[9:0]];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue the requests selected by f_on/d_on (inputs already set up) at the
  // current negedge and follow them to completion.
  task automatic serve(input bit f_on, input bit d_on);
    int  lat_f, lat_d, exp_f, exp_d, re_cnt, we_cnt, exp_re;
    bit  f_pend, d_pend, f_first;
    lat_f = MEM_LAT + 1;
    lat_d = d_we ? 2 : MEM_LAT + 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    f_first = f_on && (!d_on || f_turn);
`else
    f_first = f_on && !d_on;
`endif
    if (f_on && d_on) begin
      if (f_first) begin
        exp_f = lat_f;
        exp_d = lat_f + 1 + lat_d;
      end else begin
        exp_d = lat_d;
        exp_f = lat_d + 1 + lat_f;
      end
    end else begin
      exp_f = lat_f;
      exp_d = lat_d;
    end
    exp_re = (f_on ? MEM_LAT : 0) + ((d_on && !d_we) ? MEM_LAT : 0);
    f_pend = f_on;
    d_pend = d_on;
    re_cnt = 0;
    we_cnt = 0;
    f_req  = f_on;
    d_req  = d_on;
    for (int cyc = 1; cyc <= 64 && (f_pend || d_pend); cyc++) begin
      @(negedge clk);
      check_val("re_we_excl", 32'(mem_re & mem_we), 0);
      check_val("ack_excl", 32'(f_ack & d_ack), 0);
      if (mem_re) re_cnt++;
      if (mem_we) begin
        we_cnt++;
        check_val("wr_adr", 32'(mem_adr), 32'(d_adr));
        check_val("wr_data", 32'(mem_wdata), 32'(d_wdata));
      end
      if (f_ack) begin
        if (!f_pend) begin
          check_val("f_spurious_ack", 1, 0);
        end else begin
          check_val("f_ack_cycle", cyc, exp_f);
          hold_f_rdata = ref_mem[f_adr[9:0]];
          check_val("f_rdata", 32'(f_rdata), 32'(hold_f_rdata));
          check_val("d_rdata_hold", 32'(d_rdata), 32'(hold_d_rdata));
          f_pend = 1'b0;
          f_req  = 1'b0;
          f_turn = ~f_turn;
        end
      end
      if (d_ack) begin
        if (!d_pend) begin
          check_val("d_spurious_ack", 1, 0);
        end else begin
          check_val("d_ack_cycle", cyc, exp_d);
          if (d_we) begin
            ref_mem[d_adr[9:0]] = d_wdata;
          end else begin
            hold_d_rdata = ref_mem[d_adr[9:0]];
            check_val("d_rdata", 32'(d_rdata), 32'(hold_d_rdata));
          end
          check_val("f_rdata_hold", 32'(f_rdata), 32'(hold_f_rdata));
          d_pend = 1'b0;
          d_req  = 1'b0;
          f_turn = ~f_turn;
        end
      end
    end
    check_val("serve_timeout", {30'd0, f_pend, d_pend}, 0);
    f_req = 1'b0;
    d_req = 1'b0;
    check_val("mem_re_cycles", re_cnt, exp_re);
    check_val("mem_we_cycles", we_cnt, (d_on && d_we) ? 1 : 0);
    @(negedge clk);
    check_val("idle_busy", 32'(busy), 0);
    check_val("idle_acks", {30'd0, f_ack, d_ack}, 0);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    f_turn       = 1'b1;
    hold_f_rdata = '0;
    hold_d_rdata = '0;
    for (int i = 0; i < 1024; i++) begin
      mem_arr[i] = 16'($urandom);
      ref_mem[i] = mem_arr[i];
    end

    // reset held for two cycles with a fetch already requested
    rst     = 1'b1;
    f_req   = 1'b1;
    f_adr   = 13'h0003;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_adr   = '0;
    d_wdata = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("rst_acks", {30'd0, f_ack, d_ack}, 0);
      check_val("rst_strobes", {30'd0, mem_re, mem_we}, 0);
      check_val("rst_busy", 32'(busy), 0);
      check_val("rst_mem_adr", 32'(mem_adr), 0);
      check_val("rst_mem_wdata", 32'(mem_wdata), 0);
      check_val("rst_rdata", {f_rdata, d_rdata}, 0);
    end
    rst = 1'b0;
    serve(1'b1, 1'b0);

    // D write then D read of address 5
    d_we = 1'b1; d_adr = 13'h0005; d_wdata = 16'h000F;
    serve(1'b0, 1'b1);
    d_we = 1'b0;
    serve(1'b0, 1'b1);
    check_val("d_rdata_adr5", 32'(d_rdata), 32'h000F);

    // F read of address 3
    f_adr = 13'h0003;
    serve(1'b1, 1'b0);

    // tied requests, four back-to-back services
    f_adr = 13'h0005; d_we = 1'b0; d_adr = 13'h0003;
    serve(1'b1, 1'b1);
    d_we = 1'b1; d_adr = 13'h0005; d_wdata = 16'h1234;
    serve(1'b1, 1'b1);

    // random mix of single and tied requests over a small address window
    for (int i = 0; i < 40; i++) begin
      int sel;
      sel     = int'($urandom_range(0, 2));
      d_we    = 1'($urandom_range(0, 1));
      d_adr   = 13'($urandom_range(0, 15));
      f_adr   = 13'($urandom_range(0, 15));
      d_wdata = 16'($urandom);
      serve(sel != 1, sel != 0);
    end

    // reset during the second ACCESS cycle of a fetch read
    f_adr = 13'h0007;
    f_req = 1'b1;
    @(negedge clk);
    check_val("abort_re_first", 32'(mem_re), 1);
    @(negedge clk);
    check_val("abort_re_second", 32'(mem_re), 1);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    f_req = 1'b0;
    f_turn       = 1'b1;
    hold_f_rdata = '0;
    hold_d_rdata = '0;
    check_val("abort_re_drop", 32'(mem_re), 0);
    check_val("abort_busy", 32'(busy), 0);
    check_val("abort_ack", {30'd0, f_ack, d_ack}, 0);
    check_val("abort_rdata", {f_rdata, d_rdata}, 0);
    @(negedge clk);
    check_val("abort_ack_after", {30'd0, f_ack, d_ack}, 0);
    check_val("abort_idle", 32'(busy), 0);
    serve(1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mem_port_arbiter

`default_nettype wire
